// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the byte-serial SPI display transmit engine.
package spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int unsigned BYTE_BITS          = 8;
  localparam int unsigned HALF_PERIODS       = 2 * BYTE_BITS;
  localparam int unsigned CLK_DIV_DEFAULT    = 4;
  localparam int unsigned GAP_CYCLES_DEFAULT = 8;

endpackage

// File: rtl/spi_dc_tx_if.sv
// Upstream byte/dc handshake between the display sequencer and spi_dc_tx.
interface spi_dc_tx_if;
  import spi_tx_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [BYTE_BITS-1:0] in_data;
  logic                 in_dc;

  modport master (output in_valid, output in_data, output in_dc, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_dc, output in_ready);

endinterface

// File: rtl/spi_half_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV enabled cycles, restarted by clear.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned    CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == '0);

  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      cnt <= RELOAD;
    end else if (enable) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

endmodule

// File: rtl/spi_dc_tx.sv
// SPI mode-0 byte transmitter with per-byte cs framing, held dc line and idle gap.
// Optional receive path enabled by defining SPI_RX_EN.
module spi_dc_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 rst,
  spi_dc_tx_if.slave           up,
  output logic                 sck,
  output logic                 mosi,
  output logic                 cs,
  output logic                 dc,
  input  logic                 miso,
  output logic                 busy,
  output logic                 done,
  output logic [BYTE_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam int unsigned   GW       = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [3:0]    LAST_HALF = 4'(HALF_PERIODS - 1);

  state_t               state, state_d;
  logic [BYTE_BITS-1:0] shreg, shreg_d;
  logic [3:0]           half, half_d;
  logic [GW-1:0]        gap_cnt, gap_d;
  logic                 sck_d, mosi_d, cs_d, dc_d, busy_d, done_d;
  logic [BYTE_BITS-1:0] rx_data_d;
  logic                 rx_valid_d;
  logic                 accept, tick, tick_en;

  assign up.in_ready = (state == IDLE);
  assign accept      = up.in_valid && (state == IDLE);
  assign tick_en     = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK    (CLK),
    .rst    (rst),
    .clear  (accept),
    .enable (tick_en),
    .tick   (tick)
  );

`ifdef SPI_RX_EN
  logic [BYTE_BITS-1:0] rx_sh, rx_sh_d;
  logic                 rx_sample;
  // Rising sck edges: leaving SETUP, and ending every low half-period except the last.
  assign rx_sample = tick && ((state == SETUP) ||
                              ((state == SHIFT) && half[0] && (half != LAST_HALF)));
`else
  logic unused_miso;
  assign unused_miso = miso;
`endif

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    half_d     = half;
    gap_d      = gap_cnt;
    sck_d      = sck;
    mosi_d     = mosi;
    cs_d       = cs;
    dc_d       = dc;
    busy_d     = busy;
    done_d     = 1'b0;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
`ifdef SPI_RX_EN
    rx_sh_d    = rx_sh;
    if (rx_sample) rx_sh_d = {rx_sh[BYTE_BITS-2:0], miso};
`endif
    case (state)
      IDLE: begin
        if (up.in_valid) begin
          shreg_d = up.in_data;
          mosi_d  = up.in_data[BYTE_BITS-1];
          cs_d    = 1'b0;
          dc_d    = up.in_dc;
          busy_d  = 1'b1;
          half_d  = '0;
`ifdef SPI_RX_EN
          rx_sh_d = '0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (half == LAST_HALF) begin
            state_d = HOLD;
          end else begin
            sck_d  = ~sck;
            half_d = half + 4'd1;
            // Falling edges advance mosi; the 8th fall leaves bit 0 on the line.
            if (!half[0] && (half != LAST_HALF - 4'd1)) begin
              mosi_d  = shreg[BYTE_BITS-2];
              shreg_d = {shreg[BYTE_BITS-2:0], shreg[BYTE_BITS-1]};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_d   = 1'b1;
          mosi_d = 1'b0;
          done_d = 1'b1;
`ifdef SPI_RX_EN
          rx_data_d  = rx_sh;
          rx_valid_d = 1'b1;
`endif
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      half     <= '0;
      gap_cnt  <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      dc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
`ifdef SPI_RX_EN
      rx_sh    <= '0;
`endif
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      half     <= half_d;
      gap_cnt  <= gap_d;
      sck      <= sck_d;
      mosi     <= mosi_d;
      cs       <= cs_d;
      dc       <= dc_d;
      busy     <= busy_d;
      done     <= done_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
`ifdef SPI_RX_EN
      rx_sh    <= rx_sh_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_dc_tx.sv
// Directed bench for spi_dc_tx: default instance (A) and CLK_DIV=1/GAP_CYCLES=0 instance (B).
module tb_spi_dc_tx;
  import spi_tx_pkg::*;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  spi_dc_tx_if ifa ();
  spi_dc_tx_if ifb ();

  logic sck_a, mosi_a, cs_a, dc_a, busy_a, done_a, rxv_a, miso_a;
  logic sck_b, mosi_b, cs_b, dc_b, busy_b, done_b, rxv_b, miso_b;
  logic [7:0] rxd_a, rxd_b;

  assign miso_a = mosi_a;
  assign miso_b = mosi_b;

  spi_dc_tx dut_a (
    .CLK(CLK), .rst(rst), .up(ifa), .sck(sck_a), .mosi(mosi_a), .cs(cs_a), .dc(dc_a),
    .miso(miso_a), .busy(busy_a), .done(done_a), .rx_data(rxd_a), .rx_valid(rxv_a)
  );

  spi_dc_tx #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
    .CLK(CLK), .rst(rst), .up(ifb), .sck(sck_b), .mosi(mosi_b), .cs(cs_b), .dc(dc_b),
    .miso(miso_b), .busy(busy_b), .done(done_b), .rx_data(rxd_b), .rx_valid(rxv_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc++;

  logic [1:0] w_sck, w_mosi, w_cs, w_dc, w_done, w_rxv, w_rdy, w_vld;
  assign w_sck  = {sck_b, sck_a};
  assign w_mosi = {mosi_b, mosi_a};
  assign w_cs   = {cs_b, cs_a};
  assign w_dc   = {dc_b, dc_a};
  assign w_done = {done_b, done_a};
  assign w_rxv  = {rxv_b, rxv_a};
  assign w_rdy  = {ifb.in_ready, ifa.in_ready};
  assign w_vld  = {ifb.in_valid, ifa.in_valid};

  int rises[2], last_rises[2], cs_low_run[2], last_cs_low[2], cs_high_run[2], last_cs_high[2];
  int done_cnt[2], rxv_cnt[2], rxv_with_done[2], dc_chg_low[2], sck_edges[2];
  int cs_rise_cyc[2], rdy_rise_cyc[2], acc_gap[2], gap_max[2], last_gap_max[2];
  int acc_last[2]   = '{-1, -1};
  int prev_rise[2]  = '{-1, -1};
  logic [7:0] cap[2], last_cap[2];
  logic dc_at_fall[2];
  logic [1:0] sck_q = '0, cs_q = '1, dc_q = '0, rdy_q = '0;

  // Frame observer: sampled on the falling CLK edge, away from DUT updates.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!w_cs[i] && cs_q[i]) begin
        dc_at_fall[i]   = w_dc[i];
        rises[i]        = 0;
        cap[i]          = 8'h00;
        gap_max[i]      = 0;
        prev_rise[i]    = -1;
        last_cs_high[i] = cs_high_run[i];
        cs_low_run[i]   = 0;
      end
      if (w_cs[i] && !cs_q[i]) begin
        last_cs_low[i]  = cs_low_run[i];
        last_rises[i]   = rises[i];
        last_cap[i]     = cap[i];
        last_gap_max[i] = gap_max[i];
        cs_rise_cyc[i]  = cyc;
        cs_high_run[i]  = 0;
      end
      if (!w_cs[i]) cs_low_run[i]++; else cs_high_run[i]++;
      if (w_sck[i] && !sck_q[i]) begin
        rises[i]++;
        cap[i] = {cap[i][6:0], w_mosi[i]};
        if (prev_rise[i] >= 0 && (cyc - prev_rise[i]) > gap_max[i]) gap_max[i] = cyc - prev_rise[i];
        prev_rise[i] = cyc;
      end
      if (w_sck[i] !== sck_q[i]) sck_edges[i]++;
      if (!w_cs[i] && !cs_q[i] && (w_dc[i] !== dc_q[i])) dc_chg_low[i]++;
      if (w_done[i]) begin
        done_cnt[i]++;
        if (w_rxv[i]) rxv_with_done[i]++;
      end
      if (w_rxv[i]) rxv_cnt[i]++;
      if (w_rdy[i] && !rdy_q[i]) rdy_rise_cyc[i] = cyc;
      if (w_vld[i] && w_rdy[i]) begin
        if (acc_last[i] >= 0) acc_gap[i] = cyc - acc_last[i];
        acc_last[i] = cyc;
      end
      sck_q[i] = w_sck[i];
      cs_q[i]  = w_cs[i];
      dc_q[i]  = w_dc[i];
      rdy_q[i] = w_rdy[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int i, input int prev, input int budget, input string tag);
    int k = 0;
    while (done_cnt[i] == prev && k < budget) begin
      tick(1);
      k++;
    end
    if (done_cnt[i] == prev) begin
      checks++;
      errors++;
      $error("FAIL %s: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_ready(input int i, input int budget, input string tag);
    int k = 0;
    while (!w_rdy[i] && k < budget) begin
      tick(1);
      k++;
    end
    if (!w_rdy[i]) begin
      checks++;
      errors++;
      $error("FAIL %s: in_ready not seen within %0d cycles", tag, budget);
    end
  endtask

  int d, r, e0, e1, rvd;

  initial begin
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.in_dc = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.in_dc = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_cs",       cs_a, 1);
    check("rst_sck",      sck_a, 0);
    check("rst_mosi",     mosi_a, 0);
    check("rst_dc",       dc_a, 0);
    check("rst_busy",     busy_a, 0);
    check("rst_done",     done_a, 0);
    check("rst_rx_data",  rxd_a, 0);
    check("rst_rx_valid", rxv_a, 0);
    check("rst_in_ready", ifa.in_ready, 1);
    check("rst_b_cs",     cs_b, 1);

    // Idle for 50 cycles
    e0 = sck_edges[0]; e1 = sck_edges[1]; d = done_cnt[0];
    tick(50);
    check("idle_sck_a",  sck_edges[0], e0);
    check("idle_sck_b",  sck_edges[1], e1);
    check("idle_done_a", done_cnt[0], d);
    check("idle_ready",  ifa.in_ready, 1);

    // Single byte 0xA5, dc=1
    ifa.in_data = 8'hA5; ifa.in_dc = 1'b1; ifa.in_valid = 1'b1;
    tick(1);
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.in_dc = 1'b0;
    check("a5_cs_low",    cs_a, 0);
    check("a5_dc",        dc_a, 1);
    check("a5_mosi_msb",  mosi_a, 1);
    check("a5_busy",      busy_a, 1);
    check("a5_not_ready", ifa.in_ready, 0);
    wait_done(0, d, 200, "a5_done");
    check("a5_rises",     last_rises[0], 8);
    check("a5_bits",      last_cap[0], 8'hA5);
    check("a5_cs_len",    last_cs_low[0], 72);
    check("a5_dc_at_cs",  dc_at_fall[0], 1);
    check("a5_done_once", done_cnt[0], d + 1);
    check("a5_mosi_idle", mosi_a, 0);
    check("a5_dc_held",   dc_a, 1);
    check("a5_sck_per",   last_gap_max[0], 8);
    wait_ready(0, 50, "a5_ready");
    tick(1);
    check("a5_ready_gap", rdy_rise_cyc[0] - cs_rise_cyc[0], 8);
    check("a5_busy_end",  busy_a, 0);

    // Back-to-back 0xAE/dc0 then 0x81/dc1 with in_valid held high
    d = done_cnt[0];
    ifa.in_data = 8'hAE; ifa.in_dc = 1'b0; ifa.in_valid = 1'b1;
    tick(1);
    ifa.in_data = 8'h81; ifa.in_dc = 1'b1;
    wait_done(0, d, 200, "b2b_done1");
    check("b2b_bits1",  last_cap[0], 8'hAE);
    check("b2b_dc1",    dc_at_fall[0], 0);
    wait_ready(0, 50, "b2b_ready");
    tick(1);
    ifa.in_valid = 1'b0;
    wait_done(0, d + 1, 200, "b2b_done2");
    check("b2b_spacing", acc_gap[0], 81);
    check("b2b_cs_high", last_cs_high[0], 9);
    check("b2b_bits2",   last_cap[0], 8'h81);
    check("b2b_rises2",  last_rises[0], 8);
    check("b2b_dc2",     dc_at_fall[0], 1);
    check("b2b_dc_stable", dc_chg_low[0], 0);

    // CLK_DIV=1, GAP_CYCLES=0, 0xFF twice
    d = done_cnt[1];
    ifb.in_data = 8'hFF; ifb.in_dc = 1'b1; ifb.in_valid = 1'b1;
    tick(1);
    wait_done(1, d, 60, "cor_done1");
    ifb.in_valid = 1'b0;
    check("cor_cs_len",  last_cs_low[1], 18);
    check("cor_bits",    last_cap[1], 8'hFF);
    check("cor_rises",   last_rises[1], 8);
    check("cor_sck_per", last_gap_max[1], 2);
    wait_done(1, d + 1, 60, "cor_done2");
    check("cor_spacing", acc_gap[1], 19);
    check("cor_cs_high", last_cs_high[1], 1);
    check("cor_bits2",   last_cap[1], 8'hFF);

    // Reset after the 3rd sck rising edge
    d = done_cnt[0]; r = rxv_cnt[0];
    ifa.in_data = 8'h5A; ifa.in_dc = 1'b1; ifa.in_valid = 1'b1;
    tick(1);
    ifa.in_valid = 1'b0;
    tick(1);
    for (int k = 0; k < 100 && rises[0] < 3; k++) tick(1);
    check("mid_reached_3", rises[0], 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_cs",    cs_a, 1);
    check("mid_sck",   sck_a, 0);
    check("mid_mosi",  mosi_a, 0);
    check("mid_dc",    dc_a, 0);
    check("mid_busy",  busy_a, 0);
    check("mid_ready", ifa.in_ready, 1);
    tick(100);
    check("mid_no_done", done_cnt[0], d);
    check("mid_no_rxv",  rxv_cnt[0], r);

    // Next byte after reset: 0x3C, also looped back through miso
    rvd = rxv_with_done[0];
    ifa.in_data = 8'h3C; ifa.in_dc = 1'b0; ifa.in_valid = 1'b1;
    tick(1);
    ifa.in_valid = 1'b0;
    wait_done(0, d, 200, "post_done");
    check("post_bits",   last_cap[0], 8'h3C);
    check("post_rises",  last_rises[0], 8);
    check("post_cs_len", last_cs_low[0], 72);
    check("post_done1",  done_cnt[0], d + 1);
`ifdef SPI_RX_EN
    check("rx_data",      rxd_a, 8'h3C);
    check("rx_with_done", rxv_with_done[0], rvd + 1);
    check("rx_count",     rxv_cnt[0], r + 1);
`else
    check("rx_data_zero", rxd_a, 8'h00);
    check("rx_valid_a",   rxv_cnt[0], 0);
    check("rx_valid_b",   rxv_cnt[1], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
